// File: rtl/nibble_packer_8.sv
`default_nettype none
// ============================================================================
// Module      : nibble_packer_8
// Description : Packs pairs of valid nibbles into bytes and buffers them in a
//               show-ahead FIFO drained by a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_packer_8 #(
    parameter int DEPTH     = 4,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [3:0]               data_in,
    input  logic                     valid_in,
    input  logic                     ready_in,
    output logic [7:0]               data_out,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     half_pending,
    output logic                     overflow
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    c_full = (AW+1)'(DEPTH);

    logic [3:0]    r_half;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic          w_push_try;
    logic          w_push;
    logic [7:0]    w_byte;

    generate
        if (LOW_FIRST) begin : g_low_first
            assign w_byte = {data_in, r_half};
        end else begin : g_high_first
            assign w_byte = {r_half, data_in};
        end
    endgenerate

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_pop      = (r_count != '0) && ready_in;
    assign w_push_try = valid_in && half_pending;
    assign w_push     = w_push_try && ((r_count != c_full) || w_pop);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_half       <= 4'h0;
            half_pending <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            overflow     <= 1'b0;
        end else begin
            if (valid_in) begin
                if (!half_pending) begin
                    r_half       <= data_in;
                    half_pending <= 1'b1;
                end else begin
                    half_pending <= 1'b0;
                end
            end

            if (w_push_try && !w_push) begin
                overflow <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    assign valid_out  = (r_count != '0);
    assign data_out   = valid_out ? r_mem[r_rd_ptr] : 8'h00;
    assign fill_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_packer_8
// Description : Self-checking bench for both nibble orders against a queue
//               model; directed scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_packer_8;

    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset_L  = 1'b1;
    logic [3:0] data_in  = 4'h0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b0;

    logic [7:0] lo_data, hi_data;
    logic       lo_valid, hi_valid, lo_half, hi_half, lo_ovf, hi_ovf;
    logic [2:0] lo_fill, hi_fill;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_packer_8 #(.DEPTH(DEPTH), .LOW_FIRST(1'b1)) u_dut_lo (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .data_out(lo_data), .valid_out(lo_valid),
        .fill_level(lo_fill), .half_pending(lo_half), .overflow(lo_ovf)
    );

    nibble_packer_8 #(.DEPTH(DEPTH), .LOW_FIRST(1'b0)) u_dut_hi (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .data_out(hi_data), .valid_out(hi_valid),
        .fill_level(hi_fill), .half_pending(hi_half), .overflow(hi_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: queue holds bytes in low-first order {second, first}.
    logic [7:0] m_q[$];
    logic [3:0] m_half = 4'h0;
    bit         m_pend = 1'b0;
    bit         m_ovf  = 1'b0;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_q.delete();
            m_half = 4'h0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            bit pop, accept, try_push;
            pop      = (m_q.size() > 0) && ready_in;
            try_push = valid_in && m_pend;
            accept   = try_push && ((m_q.size() < DEPTH) || pop);
            if (try_push && !accept) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back({data_in, m_half});
            if (valid_in) begin
                if (!m_pend) begin
                    m_half = data_in;
                    m_pend = 1'b1;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [7:0] e_lo, e_hi;
        e_lo = (m_q.size() > 0) ? m_q[0] : 8'h00;
        e_hi = {e_lo[3:0], e_lo[7:4]};
        chk("lo_valid", 32'(lo_valid), 32'(m_q.size() > 0));
        chk("lo_data",  32'(lo_data),  32'(e_lo));
        chk("lo_fill",  32'(lo_fill),  32'(m_q.size()));
        chk("lo_half",  32'(lo_half),  32'(m_pend));
        chk("lo_ovf",   32'(lo_ovf),   32'(m_ovf));
        chk("hi_valid", 32'(hi_valid), 32'(m_q.size() > 0));
        chk("hi_data",  32'(hi_data),  32'(e_hi));
        chk("hi_fill",  32'(hi_fill),  32'(m_q.size()));
        chk("hi_half",  32'(hi_half),  32'(m_pend));
        chk("hi_ovf",   32'(hi_ovf),   32'(m_ovf));
    endtask

    // Inputs change on the falling edge; outputs are compared there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [3:0] d, input bit r);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        step();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        step();
        step();
        reset_L = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain_exp [4];
        drain_exp = '{8'h21, 8'h43, 8'h65, 8'h87};

        #1 reset_L = 1'b0;
        step();
        step();
        chk("rst_data",  32'(lo_data),  32'h00);
        chk("rst_valid", 32'(lo_valid), 32'h0);
        chk("rst_fill",  32'(lo_fill),  32'h0);
        chk("rst_ovf",   32'(lo_ovf),   32'h0);
        reset_L = 1'b1;

        // Basic pack, one-cycle latency, pop on next edge
        drive(1'b1, 4'h0, 1'b1);
        drive(1'b1, 4'hA, 1'b1);
        chk("pack_lo_A0",    32'(lo_data),  32'hA0);
        chk("pack_valid",    32'(lo_valid), 32'h1);
        drive(1'b0, 4'h0, 1'b1);
        chk("popped_valid",  32'(lo_valid), 32'h0);
        chk("popped_data",   32'(lo_data),  32'h00);

        // Nibble order
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'hF, 1'b1);
        chk("order_hi_5F", 32'(hi_data), 32'h5F);
        chk("order_lo_F5", 32'(lo_data), 32'hF5);
        drive(1'b0, 4'h0, 1'b1);

        // Gaps in valid
        drive(1'b1, 4'h3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'($urandom), 1'b1);
            chk("gap_half",  32'(lo_half),  32'h1);
            chk("gap_valid", 32'(lo_valid), 32'h0);
        end
        drive(1'b1, 4'hC, 1'b1);
        chk("gap_byte_C3", 32'(lo_data), 32'hC3);
        drive(1'b0, 4'h0, 1'b1);

        // Fill and overflow
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            if (i == 8) chk("fill_at_8", 32'(lo_fill), 32'h4);
        end
        chk("ovf_set",     32'(lo_ovf),  32'h1);
        chk("ovf_fill",    32'(lo_fill), 32'h4);
        chk("drain_0",     32'(lo_data), 32'(drain_exp[0]));
        for (int k = 1; k < 4; k++) begin
            drive(1'b0, 4'h0, 1'b1);
            chk("drain_k", 32'(lo_data), 32'(drain_exp[k]));
        end
        drive(1'b0, 4'h0, 1'b1);
        chk("drain_empty", 32'(lo_valid), 32'h0);
        chk("ovf_sticky",  32'(lo_ovf),   32'h1);

        // Push while full with a simultaneous pop
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b0);
        drive(1'b1, 4'h9, 1'b0);
        drive(1'b1, 4'hB, 1'b1);
        chk("fullpop_ovf",  32'(lo_ovf),  32'h0);
        chk("fullpop_fill", 32'(lo_fill), 32'h4);
        chk("fullpop_head", 32'(lo_data), 32'h43);
        for (int k = 0; k < 3; k++) drive(1'b0, 4'h0, 1'b1);
        chk("fullpop_new",  32'(lo_data), 32'hB9);
        drive(1'b0, 4'h0, 1'b1);

        // Asynchronous reset mid-operation
        for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), 1'b0);
        chk("pre_rst_fill", 32'(lo_fill), 32'h2);
        chk("pre_rst_half", 32'(lo_half), 32'h1);
        valid_in = 1'b0;
        #2 reset_L = 1'b0;
        #1;
        chk("arst_fill",  32'(lo_fill),  32'h0);
        chk("arst_half",  32'(lo_half),  32'h0);
        chk("arst_valid", 32'(lo_valid), 32'h0);
        chk("arst_data",  32'(lo_data),  32'h00);
        step();
        reset_L = 1'b1;
        drive(1'b1, 4'h7, 1'b1);
        drive(1'b1, 4'h8, 1'b1);
        chk("post_rst_87", 32'(lo_data), 32'h87);
        drive(1'b0, 4'h0, 1'b1);
        chk("post_rst_one", 32'(lo_valid), 32'h0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_L = 1'b0;
                step();
                reset_L = 1'b1;
            end
            drive(($urandom_range(0, 9) < 6), 4'($urandom), ($urandom_range(0, 9) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_packer_8.md
Name: nibble_packer_8

Overview:
Downstream stage of the 4:1 valid mux. Consumes the muxed 4-bit data/valid stream and packs each pair of consecutive valid nibbles into one byte. Bytes are buffered in a small show-ahead FIFO and drained through a valid/ready handshake toward the next consumer. The upstream mux has no backpressure, so FIFO overrun is flagged with a sticky overflow bit and is never stalled.

Parameters:
DEPTH, 4, byte FIFO entries; power of two, minimum 2.
LOW_FIRST, 1, 1: first nibble of a pair goes to data_out[3:0]; 0: first nibble goes to data_out[7:4].

Ports:
clk  input  1  single clock, all state on rising edge.
reset_L  input  1  asynchronous active-low reset.
data_in  input  4  nibble from mux data_out.
valid_in  input  1  nibble qualifier from mux valid_out.
ready_in  input  1  downstream can accept data_out this cycle.
data_out  output  8  FIFO head byte; 8'h00 when FIFO empty.
valid_out  output  1  FIFO non-empty.
fill_level  output  clog2(DEPTH)+1  bytes currently stored.
half_pending  output  1  first nibble of a pair held, awaiting its partner.
overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release on next clk edge): half register 4'h0, half_pending 0, read/write pointers 0, fill_level 0, valid_out 0, data_out 8'h00, overflow 0. Asserting reset mid-pair or with a non-empty FIFO discards everything, with no partial byte emitted.
- valid_in=0: no change to the half register or half_pending. A pending nibble is held indefinitely and there is no timeout.
- valid_in=1, half_pending=0: capture data_in into the half register and set half_pending to 1.
- valid_in=1, half_pending=1: form the byte as {data_in, half} when LOW_FIRST=1, or {half, data_in} when LOW_FIRST=0. Attempt a push and clear half_pending.
- Push acceptance:
  - The push is accepted if fill_level < DEPTH.
  - The push is also accepted if fill_level == DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set to 1, and FIFO contents are unchanged.
  - half_pending is cleared in all cases.
- Pop occurs when valid_out && ready_in at the rising edge, and the read pointer advances.
- ready_in is ignored while the FIFO is empty.
- Simultaneous push and pop: fill_level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. fill_level is derived with an extra bit so that full (DEPTH) and empty (0) are distinct.
- Latency: when the second nibble is sampled at edge N, with the FIFO previously empty, valid_out=1 and data_out=byte immediately after edge N. That is one cycle from second nibble to output.
- data_out and valid_out are registered or derived from registered state only, with no combinational path from data_in or valid_in. data_out must not depend combinationally on ready_in.
- overflow clears only on reset.
- No state machine beyond the half-pending bit and the FIFO counters. half_pending has two states:
  - EMPTY to HALF on valid_in.
  - HALF to EMPTY on valid_in.

Test Plan:
- Reset and basic pack. Hold reset_L=0 for 2 cycles; all outputs read 0. Release with LOW_FIRST=1, ready_in=1, and send valid nibbles 4'h0 then 4'hA. Required: data_out=8'hA0 and valid_out=1 one cycle after the second nibble, popped on the next edge, then valid_out=0 and data_out=8'h00.
- Order parameter. With LOW_FIRST=0, send 4'h5 then 4'hF. Required: data_out=8'h5F.
- Gaps in valid. Send nibble 4'h3, then valid_in=0 for 5 cycles (half_pending=1 throughout, valid_out=0), then nibble 4'hC. Required: byte 8'hC3.
- Fill and overflow. With DEPTH=4 and ready_in=0, send 10 nibbles 4'h1..4'hA. Required:
  - fill_level=4 after the 8th nibble.
  - The 5th byte (8'hA9) is dropped and overflow=1.
  - With ready_in=1, the drain yields 8'h21, 8'h43, 8'h65, 8'h87 in order, then valid_out=0.
  - overflow stays 1.
- Push while full with pop. With the FIFO full and ready_in=1 on the same edge that the second nibble of a pair arrives, required: no overflow, fill_level stays 4, and the new byte appears after 3 more pops.
- Reset mid-operation. With half_pending=1 and fill_level=2, assert reset_L=0 asynchronously between edges. Required: outputs go to 0 immediately. After release, nibbles 4'h7 then 4'h8 yield exactly one byte, 8'h87.
